// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for FIFO-to-stream width converters: FSM encoding and
// word/beat ratio helpers.
package fifo_stream_reader_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic int ratio_of(input int fifo_width, input int out_width);
    return fifo_width / out_width;
  endfunction

  function automatic int log2_of(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A ratio of 1 still needs a 1-bit index so the splitter ports stay legal.
  function automatic int idx_width(input int ratio);
    return (log2_of(ratio) < 1) ? 1 : log2_of(ratio);
  endfunction

endpackage

// File: rtl/word_splitter.sv
// Holds the current FIFO word and hands out one OUT_WIDTH chunk per take,
// in low-first or high-first order.
module word_splitter
  import fifo_stream_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  take_word,
  input  logic                  take_held,
  input  logic [FIFO_WIDTH-1:0] word,
  output logic                  held_valid,
  output logic [OUT_WIDTH-1:0]  chunk
);

  localparam int RATIO = ratio_of(FIFO_WIDTH, OUT_WIDTH);
  localparam int IDX_W = idx_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [FIFO_WIDTH-1:0] held;
  logic [IDX_W-1:0]      chunk_idx;
  logic                  has_held;

  function automatic logic [OUT_WIDTH-1:0] pick(input logic [FIFO_WIDTH-1:0] w,
                                                input logic [IDX_W-1:0] i);
    int slot;
    slot = (MSB_FIRST != 0) ? (RATIO - 1 - int'(i)) : int'(i);
    return w[slot*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  // Chunk 0 of a fresh word comes straight from the FIFO head.
  always_comb begin
    chunk = has_held ? pick(held, chunk_idx) : pick(word, '0);
  end

  assign held_valid = has_held;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      held      <= '0;
      chunk_idx <= '0;
      has_held  <= 1'b0;
    end else if (take_word) begin
      held      <= word;
      chunk_idx <= (RATIO > 1) ? IDX_W'(1) : '0;
      has_held  <= (RATIO > 1);
    end else if (take_held) begin
      if (chunk_idx == LAST_IDX) begin
        chunk_idx <= '0;
        has_held  <= 1'b0;
      end else begin
        chunk_idx <= chunk_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port into a valid/ready beat stream framed into packets
// of pkt_len beats with sop/eop markers.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_re,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready,
  output logic                  busy
);

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 first;
  logic                 held_valid;
  logic [OUT_WIDTH-1:0] chunk;
  logic                 slot_free, want_beat;
  logic                 start, finish, load, take_word, take_held;

  // Handshake: a beat transfers on a clock edge where out_valid and out_ready
  // are both high; out_data/out_sop/out_eop hold while out_valid && !out_ready.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    load       = 1'b0;
    take_word  = 1'b0;
    take_held  = 1'b0;
    fifo_re    = 1'b0;
    slot_free  = !out_valid || out_ready;
    want_beat  = (state == S_RUN) && slot_free && (beats_left != '0);
    if (reset || abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && (pkt_len != '0)) begin
            start      = 1'b1;
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (want_beat) begin
            if (held_valid) begin
              take_held = 1'b1;
              load      = 1'b1;
            end else if (!fifo_empty) begin
              take_word = 1'b1;
              fifo_re   = 1'b1;
              load      = 1'b1;
            end
          end
          if (out_valid && out_ready && out_eop) begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      beats_left <= '0;
      first      <= 1'b0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
    end else begin
      state <= state_next;
      if (abort) begin
        beats_left <= '0;
        first      <= 1'b0;
        out_valid  <= 1'b0;
        out_sop    <= 1'b0;
        out_eop    <= 1'b0;
      end else if (start) begin
        beats_left <= pkt_len;
        first      <= 1'b1;
      end else if (load) begin
        out_data   <= chunk;
        out_valid  <= 1'b1;
        out_sop    <= first;
        out_eop    <= (beats_left == LEN_WIDTH'(1));
        first      <= 1'b0;
        beats_left <= beats_left - LEN_WIDTH'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == S_RUN);

  // Leftover chunks never leak into the next packet.
  word_splitter #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_splitter (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort || start || finish),
    .take_word (take_word),
    .take_held (take_held),
    .word      (fifo_rdata),
    .held_valid(held_valid),
    .chunk     (chunk)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: three instances (LSB-first 32/8, MSB-first 32/8,
// 8/8) fed by queue-backed FIFO models, checked against one expected-beat queue.
module tb_fifo_stream_reader;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset, abort, out_ready, force_empty;
  logic [15:0] pkt_len;
  logic        en         [N];
  logic        fifo_empty [N];
  logic        fifo_re    [N];
  logic [31:0] fifo_rdata [N];
  logic [7:0]  out_data   [N];
  logic        out_valid  [N];
  logic        out_sop    [N];
  logic        out_eop    [N];
  logic        busy       [N];

  logic [31:0] mem [N][64];
  int          wr_ptr [N] = '{default: 0};
  int          rd_ptr [N] = '{default: 0};
  int          re_count [N] = '{default: 0};
  int          re_cycle_last = 0, re_cycle_prev = 0;
  int          cyc = 0;
  logic        stall_prev [N] = '{default: 1'b0};
  logic [9:0]  stall_beat [N];

  logic [11:0] exp_q[$];
  int          compared = 0;
  int          mismatched = 0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  fifo_stream_reader u_lsb (
    .clk(clk), .reset(reset), .enable(en[0]), .abort(abort), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty[0]), .fifo_rdata(fifo_rdata[0]), .fifo_re(fifo_re[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_sop(out_sop[0]),
    .out_eop(out_eop[0]), .out_ready(out_ready), .busy(busy[0])
  );

  fifo_stream_reader #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .enable(en[1]), .abort(abort), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty[1]), .fifo_rdata(fifo_rdata[1]), .fifo_re(fifo_re[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_sop(out_sop[1]),
    .out_eop(out_eop[1]), .out_ready(out_ready), .busy(busy[1])
  );

  fifo_stream_reader #(.FIFO_WIDTH(8), .OUT_WIDTH(8)) u_r1 (
    .clk(clk), .reset(reset), .enable(en[2]), .abort(abort), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty[2]), .fifo_rdata(fifo_rdata[2][7:0]), .fifo_re(fifo_re[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_sop(out_sop[2]),
    .out_eop(out_eop[2]), .out_ready(out_ready), .busy(busy[2])
  );

  // FIFO models: head word visible while non-empty, popped on fifo_re.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = force_empty || (rd_ptr[i] == wr_ptr[i]);
      fifo_rdata[i] = mem[i][rd_ptr[i] % 64];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (fifo_re[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [11:0] got, exp;
    #1;
    for (int i = 0; i < N; i++) begin
      if (fifo_empty[i]) begin
        compared++;
        if (fifo_re[i] !== 1'b0) begin
          mismatched++;
          $display("FAIL re_while_empty inst%0d: fifo_re=%b required 0", i, fifo_re[i]);
        end
      end
      if (fifo_re[i] === 1'b1) begin
        re_count[i]++;
        if (i == 0) begin
          re_cycle_prev = re_cycle_last;
          re_cycle_last = cyc;
        end
      end
      if (stall_prev[i] && out_valid[i]) begin
        compared++;
        if ({out_sop[i], out_eop[i], out_data[i]} !== stall_beat[i]) begin
          mismatched++;
          $display("FAIL stall_hold inst%0d: got %h required %h", i,
                   {out_sop[i], out_eop[i], out_data[i]}, stall_beat[i]);
        end
      end
      stall_prev[i] = out_valid[i] && !out_ready && !reset && !abort;
      stall_beat[i] = {out_sop[i], out_eop[i], out_data[i]};
      if (out_valid[i] && out_ready) begin
        got = {2'(i), out_sop[i], out_eop[i], out_data[i]};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_beat: got inst/sop/eop/data %h, queue empty", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            mismatched++;
            $display("FAIL beat: got inst/sop/eop/data %h required %h", got, exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input int inst, input logic [31:0] w);
    mem[inst][wr_ptr[inst] % 64] = w;
    wr_ptr[inst]++;
  endtask

  task automatic expect_beat(input int inst, input logic sop, input logic eop,
                             input logic [7:0] d);
    exp_q.push_back({2'(inst), sop, eop, d});
  endtask

  // Returns on the negedge after enable was sampled (first RUN cycle).
  task automatic start_pkt(input int inst, input int len);
    @(negedge clk);
    en[inst] = 1'b1;
    pkt_len  = 16'(len);
    @(negedge clk);
    en[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      #2;
      if (!busy[inst] && exp_q.size() == 0) done = 1'b1;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s_timeout: busy=%b pending=%0d required idle/0", name, busy[inst],
               exp_q.size());
    end
  endtask

  task automatic wait_data(input int inst, input logic [7:0] d, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      #2;
      if (out_valid[inst] && out_data[inst] == d) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_wait: beat %h not seen", name, d);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; abort = 1'b0; out_ready = 1'b1; force_empty = 1'b0; pkt_len = '0;
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      compared++;
      if ({out_valid[i], out_sop[i], out_eop[i], out_data[i], busy[i], fifo_re[i]} !== 13'd0) begin
        mismatched++;
        $display("FAIL reset_outputs inst%0d: got %b required 0", i,
                 {out_valid[i], out_sop[i], out_eop[i], out_data[i], busy[i], fifo_re[i]});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int base, sop_c, eop_c;
    bit seen;
    push_word(0, 32'h44332211);
    push_word(0, 32'h88776655);
    expect_beat(0, 1, 0, 8'h11); expect_beat(0, 0, 0, 8'h22);
    expect_beat(0, 0, 0, 8'h33); expect_beat(0, 0, 0, 8'h44);
    expect_beat(0, 0, 0, 8'h55); expect_beat(0, 0, 0, 8'h66);
    expect_beat(0, 0, 0, 8'h77); expect_beat(0, 0, 1, 8'h88);
    base = re_count[0];
    start_pkt(0, 8);
    #1;
    compared++;
    if ({busy[0], fifo_re[0], out_valid[0]} !== 3'b110) begin
      mismatched++;
      $display("FAIL start_latency: busy/re/valid=%b required 110",
               {busy[0], fifo_re[0], out_valid[0]});
    end
    sop_c = 0; eop_c = 0; seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      #2;
      if (out_valid[0] && out_sop[0]) sop_c = cyc;
      if (out_valid[0] && out_eop[0] && out_ready) begin eop_c = cyc; seen = 1'b1; end
    end
    compared++;
    if (!seen || (eop_c - sop_c) != 7) begin
      mismatched++;
      $display("FAIL basic_throughput: sop..eop span %0d required 7", eop_c - sop_c);
    end
    @(negedge clk);
    #2;
    compared++;
    if (busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_busy_fall: busy=%b required 0", busy[0]);
    end
    compared++;
    if ((re_count[0] - base) != 2 || (re_cycle_last - re_cycle_prev) != 4) begin
      mismatched++;
      $display("FAIL basic_pops: count %0d gap %0d required 2 and 4", re_count[0] - base,
               re_cycle_last - re_cycle_prev);
    end
    wait_done(0, 10, "basic");
  endtask

  task automatic test_partial();
    push_word(0, 32'h44332211);
    push_word(0, 32'h88776655);
    push_word(0, 32'hCCBBAA99);
    expect_beat(0, 1, 0, 8'h11); expect_beat(0, 0, 0, 8'h22);
    expect_beat(0, 0, 0, 8'h33); expect_beat(0, 0, 0, 8'h44);
    expect_beat(0, 0, 1, 8'h55);
    start_pkt(0, 5);
    wait_done(0, 30, "partial_a");
    expect_beat(0, 1, 1, 8'h99);
    start_pkt(0, 1);
    wait_done(0, 30, "partial_b");
    compared++;
    if (rd_ptr[0] != wr_ptr[0]) begin
      mismatched++;
      $display("FAIL partial_fifo_level: %0d words left required 0", wr_ptr[0] - rd_ptr[0]);
    end
  endtask

  task automatic test_backpressure();
    logic ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit done;
    push_word(0, 32'hD4C3B2A1);
    push_word(0, 32'h18F7E6D5);
    expect_beat(0, 1, 0, 8'hA1); expect_beat(0, 0, 0, 8'hB2);
    expect_beat(0, 0, 0, 8'hC3); expect_beat(0, 0, 0, 8'hD4);
    expect_beat(0, 0, 0, 8'hD5); expect_beat(0, 0, 0, 8'hE6);
    expect_beat(0, 0, 0, 8'hF7); expect_beat(0, 0, 1, 8'h18);
    start_pkt(0, 8);
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      out_ready   = (k < 20) ? ready_pat[k % 4] : 1'(($urandom_range(0, 3)) != 0);
      force_empty = (k >= 9 && k < 12);
      #2;
      if (!busy[0] && exp_q.size() == 0) done = 1'b1;
    end
    out_ready = 1'b1;
    force_empty = 1'b0;
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL backpressure_timeout: pending %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    push_word(0, 32'h44332211);
    push_word(0, 32'h88776655);
    push_word(0, 32'hCCBBAA99);
    expect_beat(0, 1, 0, 8'h11); expect_beat(0, 0, 0, 8'h22);
    expect_beat(0, 0, 0, 8'h33);
    start_pkt(0, 8);
    wait_data(0, 8'h33, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    compared++;
    if ({out_valid[0], out_eop[0], busy[0]} !== 3'b000) begin
      mismatched++;
      $display("FAIL abort_outputs: valid/eop/busy=%b required 000",
               {out_valid[0], out_eop[0], busy[0]});
    end
    expect_beat(0, 1, 0, 8'h55); expect_beat(0, 0, 0, 8'h66);
    expect_beat(0, 0, 0, 8'h77); expect_beat(0, 0, 1, 8'h88);
    start_pkt(0, 4);
    wait_done(0, 30, "abort_next");
    expect_beat(0, 1, 0, 8'h99); expect_beat(0, 0, 0, 8'hAA);
    expect_beat(0, 0, 0, 8'hBB); expect_beat(0, 0, 1, 8'hCC);
    start_pkt(0, 4);
    wait_done(0, 30, "abort_drain");
  endtask

  task automatic test_reset_mid_and_zero();
    push_word(0, 32'h44332211);
    push_word(0, 32'h88776655);
    expect_beat(0, 1, 0, 8'h11); expect_beat(0, 0, 0, 8'h22);
    expect_beat(0, 0, 0, 8'h33);
    start_pkt(0, 8);
    wait_data(0, 8'h33, "reset_mid");
    reset = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if ({out_valid[0], out_sop[0], out_eop[0], out_data[0], busy[0], fifo_re[0]} !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got %b required 0",
               {out_valid[0], out_sop[0], out_eop[0], out_data[0], busy[0], fifo_re[0]});
    end
    reset = 1'b0;
    en[0] = 1'b1;
    pkt_len = 16'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      compared++;
      if ({busy[0], fifo_re[0], out_valid[0]} !== 3'b000) begin
        mismatched++;
        $display("FAIL zero_len: busy/re/valid=%b required 000",
                 {busy[0], fifo_re[0], out_valid[0]});
      end
    end
    en[0] = 1'b0;
    expect_beat(0, 1, 0, 8'h55); expect_beat(0, 0, 0, 8'h66);
    expect_beat(0, 0, 0, 8'h77); expect_beat(0, 0, 1, 8'h88);
    start_pkt(0, 4);
    wait_done(0, 30, "reset_drain");
  endtask

  task automatic test_msb_and_ratio1();
    int base;
    push_word(1, 32'h44332211);
    expect_beat(1, 1, 0, 8'h44); expect_beat(1, 0, 0, 8'h33);
    expect_beat(1, 0, 0, 8'h22); expect_beat(1, 0, 1, 8'h11);
    start_pkt(1, 4);
    wait_done(1, 30, "msb_first");
    push_word(2, 32'h000000A1);
    push_word(2, 32'h000000B2);
    push_word(2, 32'h000000C3);
    expect_beat(2, 1, 0, 8'hA1); expect_beat(2, 0, 0, 8'hB2);
    expect_beat(2, 0, 1, 8'hC3);
    base = re_count[2];
    start_pkt(2, 3);
    wait_done(2, 30, "ratio1");
    compared++;
    if ((re_count[2] - base) != 3) begin
      mismatched++;
      $display("FAIL ratio1_pops: %0d pops required 3", re_count[2] - base);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_abort();
    test_reset_mid_and_zero();
    test_msb_and_ratio1();
    repeat (2) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expected: %0d beats never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
